paint_scheduler: RTL and testbench
==================================

PAINT_SCHEDULER -- requirements
Module: paint_scheduler

Interface
REQ-001 Parameter N_REQ, 3, number of rectangle requesters (0=pointer, 1=chess, 2=upper banner).
REQ-002 Parameter START_TMO, 4, max cycles from eng_start to eng_busy rising.
REQ-003 Parameter RUN_TMO, 65535, max cycles eng_busy may stay high.
REQ-004 Clck  input  1  single clock; all logic on posedge Clck.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester request, level, held until ack.
REQ-007 req_rect  input  N_REQ*(2*`SCR_WIDTH_BITS+2*`SCR_HEIGHT_BITS)  per-requester {x_start,x_end,y_start,y_end}, slice i at index i.
REQ-008 req_color  input  N_REQ*`COLOR_SIZE  per-requester color.
REQ-009 req_cfg  input  N_REQ*3  per-requester config (square/circle code).
REQ-010 ack  output  N_REQ  one-cycle pulse to the served requester on job completion.
REQ-011 err  output  N_REQ  one-cycle pulse, same cycle as ack, if job ended by timeout.
REQ-012 eng_x_start, eng_x_end  output  `SCR_WIDTH_BITS each  latched rectangle x bounds to fill engine.
REQ-013 eng_y_start, eng_y_end  output  `SCR_HEIGHT_BITS each  latched rectangle y bounds.
REQ-014 eng_color  output  `COLOR_SIZE; eng_cfg  output  3  latched job attributes.
REQ-015 eng_start  output  1  one-cycle start pulse to fill engine.
REQ-016 eng_busy  input  1  high while fill engine is drawing.
REQ-017 grant_id  output  clog2(N_REQ)  index of current/last served requester; idle_o  output  1  high in IDLE.

Function
REQ-018 States: IDLE, LATCH, ISSUE, WAIT_BUSY, WAIT_DONE, RELEASE.
REQ-019 IDLE: if any req bit high, pick winner round-robin starting at (last_grant+1) mod N_REQ, go LATCH; else stay.
REQ-020 LATCH: copy winner's rect/color/cfg into eng_* registers; grant_id=winner; go ISSUE.
REQ-021 ISSUE: eng_start=1 for exactly this cycle; clear timer; go WAIT_BUSY.
REQ-022 WAIT_BUSY: eng_busy=1 -> WAIT_DONE, timer cleared; timer reaching START_TMO -> RELEASE with timeout flag set.
REQ-023 WAIT_DONE: eng_busy=0 -> RELEASE; timer reaching RUN_TMO -> RELEASE with timeout flag set.
REQ-024 RELEASE: ack[grant_id]=1, err[grant_id]=timeout flag, last_grant=grant_id, clear flag; go IDLE.
REQ-025 Request-to-eng_start latency: 2 cycles (IDLE sample, LATCH, ISSUE pulse).
REQ-026 eng_* outputs stable from LATCH through RELEASE; req_* changes during a job ignored.
REQ-027 Requester dropping req mid-job: job still completes and is acked.
REQ-028 Requester still high in the cycle after ack: treated as new request, subject to round-robin.
REQ-029 Round-robin wrap: last_grant=N_REQ-1 searches from 0.
REQ-030 Timer: 16-bit saturating counter; comparisons unsigned.
REQ-031 Rectangles with x_end<x_start or y_end<y_start forwarded unchanged; no clamping.
REQ-032 ack and err never asserted for more than one bit or one cycle at a time.

Reset
REQ-033 Reset=1 at posedge: state=IDLE, last_grant=N_REQ-1, timer=0, flag=0, ack=0, err=0, eng_start=0, eng_* bounds/color/cfg=0, grant_id=0, idle_o=1.
REQ-034 Reset mid-job: job dropped without ack; eng_start never reasserted until a fresh request.

Structure
REQ-035 State encodings, config codes (square=3'b000, circle=3'b001) and width macros live in shared header.v.
REQ-036 Round-robin selection is sub-module rr_pick (inputs req, last_grant; outputs valid, winner), purely combinational.

Verification
REQ-037 Single req=3'b010, busy rises cycle+1 after start, low 20 cycles later -> eng_start 2 cycles after req, ack=3'b010 once, err=0.
REQ-038 req=3'b111 held continuously from reset -> grant order 0,1,2,0; each eng_start preceded by correct latched rect.
REQ-039 eng_busy never rises -> after START_TMO=4 cycles ack and err pulse together for granted requester.
REQ-040 eng_busy held high, RUN_TMO overridden to 100 -> ack+err at cycle 100 of WAIT_DONE.
REQ-041 Reset asserted in WAIT_DONE -> idle_o=1 next cycle, no ack, outputs at reset values.
REQ-042 req_rect changed during WAIT_DONE -> eng_x_start etc. unchanged until next LATCH.

Source files
------------

// File: rtl/paint_scheduler_pkg.sv
// rtl/paint_scheduler_pkg.sv - shared widths, state encodings and config codes
package paint_scheduler_pkg;

  localparam int SCR_WIDTH_BITS  = 10;
  localparam int SCR_HEIGHT_BITS = 9;
  localparam int COLOR_SIZE      = 8;
  localparam int RECT_BITS       = 2 * SCR_WIDTH_BITS + 2 * SCR_HEIGHT_BITS;

  // Shape codes carried in the per-job config field
  localparam logic [2:0] CFG_SQUARE = 3'b000;
  localparam logic [2:0] CFG_CIRCLE = 3'b001;

  // Scheduler FSM encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LATCH     = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_RELEASE   = 3'd5;

  // One requester's rectangle slice, x_start in the most significant bits
  typedef struct packed {
    logic [SCR_WIDTH_BITS-1:0]  x_start;
    logic [SCR_WIDTH_BITS-1:0]  x_end;
    logic [SCR_HEIGHT_BITS-1:0] y_start;
    logic [SCR_HEIGHT_BITS-1:0] y_end;
  } rect_t;

endpackage

// File: rtl/paint_scheduler_rr_pick.sv
// rtl/paint_scheduler_rr_pick.sv - combinational round-robin winner selection
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int GW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic             valid,
  output logic [GW-1:0]    winner
);

  // Scan from the farthest candidate down to last_grant+1 so the nearest
  // requester after the previous winner overwrites everything else.
  always_comb begin
    logic [GW-1:0] idx;
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % N_REQ);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/paint_scheduler.sv
// rtl/paint_scheduler.sv - round-robin rectangle job scheduler for the fill engine
module paint_scheduler
  import paint_scheduler_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int START_TMO = 4,
  parameter int RUN_TMO   = 65535,
  localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                           Clck,
  input  logic                           Reset,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ*RECT_BITS-1:0]     req_rect,
  input  logic [N_REQ*COLOR_SIZE-1:0]    req_color,
  input  logic [N_REQ*3-1:0]             req_cfg,
  output logic [N_REQ-1:0]               ack,
  output logic [N_REQ-1:0]               err,
  output logic [SCR_WIDTH_BITS-1:0]      eng_x_start,
  output logic [SCR_WIDTH_BITS-1:0]      eng_x_end,
  output logic [SCR_HEIGHT_BITS-1:0]     eng_y_start,
  output logic [SCR_HEIGHT_BITS-1:0]     eng_y_end,
  output logic [COLOR_SIZE-1:0]          eng_color,
  output logic [2:0]                     eng_cfg,
  output logic                           eng_start,
  input  logic                           eng_busy,
  output logic [GW-1:0]                  grant_id,
  output logic                           idle_o
);

  localparam logic [15:0] START_LIM = 16'(START_TMO);
  localparam logic [15:0] RUN_LIM   = 16'(RUN_TMO);

  logic [2:0]            state;
  logic [GW-1:0]         last_grant;
  logic [15:0]           timer;
  logic [15:0]           timer_inc;
  logic                  tmo_flag;
  logic                  pick_valid;
  logic [GW-1:0]         pick_winner;
  rect_t                 sel_rect;
  logic [COLOR_SIZE-1:0] sel_color;
  logic [2:0]            sel_cfg;

  rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Saturating increment so a stuck engine can never wrap the timer
  assign timer_inc = (timer == 16'hFFFF) ? timer : timer + 16'd1;

  // Route the granted requester's job attributes toward the eng_* registers
  always_comb begin
    sel_rect  = '0;
    sel_color = '0;
    sel_cfg   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_rect  = rect_t'(req_rect[i*RECT_BITS +: RECT_BITS]);
        sel_color = req_color[i*COLOR_SIZE +: COLOR_SIZE];
        sel_cfg   = req_cfg[i*3 +: 3];
      end
    end
  end

  // Job sequencing FSM, timeout timer and latched job attributes
  always_ff @(posedge Clck) begin
    if (Reset) begin
      state       <= ST_IDLE;
      last_grant  <= GW'(N_REQ - 1);
      grant_id    <= '0;
      timer       <= '0;
      tmo_flag    <= 1'b0;
      eng_x_start <= '0;
      eng_x_end   <= '0;
      eng_y_start <= '0;
      eng_y_end   <= '0;
      eng_color   <= '0;
      eng_cfg     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_winner;
            state    <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          eng_x_start <= sel_rect.x_start;
          eng_x_end   <= sel_rect.x_end;
          eng_y_start <= sel_rect.y_start;
          eng_y_end   <= sel_rect.y_end;
          eng_color   <= sel_color;
          eng_cfg     <= sel_cfg;
          state       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (eng_busy) begin
            timer <= '0;
            state <= ST_WAIT_DONE;
          end else if (timer_inc >= START_LIM) begin
            tmo_flag <= 1'b1;
            state    <= ST_RELEASE;
          end else begin
            timer <= timer_inc;
          end
        end
        ST_WAIT_DONE: begin
          if (!eng_busy) begin
            state <= ST_RELEASE;
          end else if (timer_inc >= RUN_LIM) begin
            tmo_flag <= 1'b1;
            state    <= ST_RELEASE;
          end else begin
            timer <= timer_inc;
          end
        end
        ST_RELEASE: begin
          last_grant <= grant_id;
          tmo_flag   <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Completion pulses go only to the served requester, only in RELEASE
  always_comb begin
    ack = '0;
    err = '0;
    if (state == ST_RELEASE) begin
      ack[grant_id] = 1'b1;
      err[grant_id] = tmo_flag;
    end
  end

  assign eng_start = (state == ST_ISSUE);
  assign idle_o    = (state == ST_IDLE);

endmodule

// File: tb/tb_paint_scheduler.sv
// tb/tb_paint_scheduler.sv - directed table-driven bench for paint_scheduler
module tb_paint_scheduler;
  import paint_scheduler_pkg::*;

  localparam int N  = 3;
  localparam int RB = RECT_BITS;
  localparam int BUSY_HOLD = 1000;

  logic                       Clck = 1'b0;
  logic                       Reset;
  logic [N-1:0]               req;
  logic [N*RB-1:0]            req_rect;
  logic [N*COLOR_SIZE-1:0]    req_color;
  logic [N*3-1:0]             req_cfg;
  logic [N-1:0]               ack;
  logic [N-1:0]               err;
  logic [SCR_WIDTH_BITS-1:0]  eng_x_start;
  logic [SCR_WIDTH_BITS-1:0]  eng_x_end;
  logic [SCR_HEIGHT_BITS-1:0] eng_y_start;
  logic [SCR_HEIGHT_BITS-1:0] eng_y_end;
  logic [COLOR_SIZE-1:0]      eng_color;
  logic [2:0]                 eng_cfg;
  logic                       eng_start;
  logic                       eng_busy;
  logic [1:0]                 grant_id;
  logic                       idle_o;

  paint_scheduler #(
    .N_REQ     (3),
    .START_TMO (4),
    .RUN_TMO   (100)
  ) dut (
    .Clck        (Clck),
    .Reset       (Reset),
    .req         (req),
    .req_rect    (req_rect),
    .req_color   (req_color),
    .req_cfg     (req_cfg),
    .ack         (ack),
    .err         (err),
    .eng_x_start (eng_x_start),
    .eng_x_end   (eng_x_end),
    .eng_y_start (eng_y_start),
    .eng_y_end   (eng_y_end),
    .eng_color   (eng_color),
    .eng_cfg     (eng_cfg),
    .eng_start   (eng_start),
    .eng_busy    (eng_busy),
    .grant_id    (grant_id),
    .idle_o      (idle_o)
  );

  always #5 Clck = ~Clck;

  typedef struct {
    logic [2:0] req;
    int         busy_len;
    int         exp_grant;
    logic       exp_err;
    int         exp_delay;
  } vec_t;

  vec_t vecs[8];
  int n_checks = 0;
  int n_pass   = 0;

  logic [SCR_WIDTH_BITS-1:0]  c_xs[N];
  logic [SCR_WIDTH_BITS-1:0]  c_xe[N];
  logic [SCR_HEIGHT_BITS-1:0] c_ys[N];
  logic [SCR_HEIGHT_BITS-1:0] c_ye[N];
  logic [COLOR_SIZE-1:0]      c_col[N];
  logic [2:0]                 c_cfg[N];

  function automatic logic [RB-1:0] exp_rect(input int g);
    return {c_xs[g], c_xe[g], c_ys[g], c_ye[g]};
  endfunction

  task automatic tick();
    @(posedge Clck);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic load_reqs(input bit corrupt);
    for (int i = 0; i < N; i++) begin
      req_rect[i*RB +: RB]                 = corrupt ? ~exp_rect(i) : exp_rect(i);
      req_color[i*COLOR_SIZE +: COLOR_SIZE] = corrupt ? ~c_col[i] : c_col[i];
      req_cfg[i*3 +: 3]                    = corrupt ? ~c_cfg[i] : c_cfg[i];
    end
  endtask

  function automatic logic [RB-1:0] eng_rect();
    return {eng_x_start, eng_x_end, eng_y_start, eng_y_end};
  endfunction

  task automatic run_vec(input int k);
    vec_t v;
    int start_c, ack_c, ack_n;
    logic [2:0] ack_v, err_v, onehot;
    v = vecs[k];
    onehot = 3'b001 << v.exp_grant;
    check($sformatf("v%0d_idle_before", k), idle_o, 1'b1);
    req = v.req;
    start_c = 0;
    for (int c = 1; c <= 6 && start_c == 0; c++) begin
      tick();
      if (eng_start) start_c = c;
    end
    check($sformatf("v%0d_start_latency", k), start_c, 2);
    req = '0;
    check($sformatf("v%0d_grant", k), grant_id, v.exp_grant);
    check($sformatf("v%0d_rect", k), eng_rect(), exp_rect(v.exp_grant));
    check($sformatf("v%0d_color", k), eng_color, c_col[v.exp_grant]);
    check($sformatf("v%0d_cfg", k), eng_cfg, c_cfg[v.exp_grant]);
    ack_c = 0; ack_n = 0; ack_v = '0; err_v = '0;
    for (int c = 1; c <= v.exp_delay + 1; c++) begin
      tick();
      eng_busy = (v.busy_len == BUSY_HOLD) ? 1'b1 : (c <= v.busy_len);
      if (c == 3) load_reqs(1'b1);
      if (ack != '0) begin
        ack_n++;
        if (ack_c == 0) begin
          ack_c = c;
          ack_v = ack;
          err_v = err;
        end
      end
    end
    check($sformatf("v%0d_ack_cycle", k), ack_c, v.exp_delay);
    check($sformatf("v%0d_ack_value", k), ack_v, onehot);
    check($sformatf("v%0d_err_value", k), err_v, v.exp_err ? onehot : 3'b000);
    check($sformatf("v%0d_ack_count", k), ack_n, 1);
    check($sformatf("v%0d_rect_stable", k), {eng_rect(), eng_color, eng_cfg},
          {exp_rect(v.exp_grant), c_col[v.exp_grant], c_cfg[v.exp_grant]});
    eng_busy = 1'b0;
    load_reqs(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_seen, err_seen, multi_seen, stray;
    logic prev_start;
    int order[4];

    c_xs[0] = 10'd10;  c_xe[0] = 10'd100; c_ys[0] = 9'd5;   c_ye[0] = 9'd50;
    c_col[0] = 8'h11;  c_cfg[0] = CFG_SQUARE;
    c_xs[1] = 10'd200; c_xe[1] = 10'd300; c_ys[1] = 9'd60;  c_ye[1] = 9'd120;
    c_col[1] = 8'hA5;  c_cfg[1] = CFG_CIRCLE;
    c_xs[2] = 10'd900; c_xe[2] = 10'd20;  c_ys[2] = 9'd400; c_ye[2] = 9'd7;
    c_col[2] = 8'hFF;  c_cfg[2] = 3'b010;

    // req, busy_len, grant, err, ack delay after eng_start
    vecs[0] = '{3'b010, 20,        1, 1'b0, 22};
    vecs[1] = '{3'b001, 3,         0, 1'b0, 5};
    vecs[2] = '{3'b110, 1,         1, 1'b0, 3};
    vecs[3] = '{3'b101, 5,         2, 1'b0, 7};
    vecs[4] = '{3'b011, 2,         0, 1'b0, 4};
    vecs[5] = '{3'b100, 0,         2, 1'b1, 5};
    vecs[6] = '{3'b111, BUSY_HOLD, 0, 1'b1, 102};
    vecs[7] = '{3'b111, 4,         1, 1'b0, 6};

    Reset = 1'b1; req = '0; eng_busy = 1'b0;
    req_rect = '0; req_color = '0; req_cfg = '0;
    load_reqs(1'b0);
    tick(); tick();
    check("reset_idle", idle_o, 1'b1);
    check("reset_ack_err", {ack, err}, 6'b0);
    check("reset_start", eng_start, 1'b0);
    check("reset_grant", grant_id, 2'd0);
    check("reset_rect", eng_rect(), '0);
    check("reset_color_cfg", {eng_color, eng_cfg}, '0);
    Reset = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) run_vec(k);

    // Reset landing in WAIT_DONE drops the job silently
    req = 3'b001;
    tick(); tick();
    check("rst_mid_start", eng_start, 1'b1);
    req = '0;
    stray = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      eng_busy = 1'b1;
      if (ack != '0) stray++;
    end
    Reset = 1'b1; eng_busy = 1'b0;
    tick();
    check("rst_mid_idle", idle_o, 1'b1);
    check("rst_mid_ack_err", {ack, err}, 6'b0);
    check("rst_mid_grant", grant_id, 2'd0);
    check("rst_mid_eng", {eng_rect(), eng_color, eng_cfg}, '0);
    Reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (eng_start || ack != '0) stray++;
    end
    check("rst_mid_no_activity", stray, 0);

    // All requesters held from reset: grants rotate 0,1,2,0
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
    Reset = 1'b1; req = 3'b111;
    tick();
    Reset = 1'b0;
    n_seen = 0; err_seen = 0; multi_seen = 0; prev_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      eng_busy = prev_start;
      prev_start = eng_start;
      if (err != '0) err_seen++;
      if ($countones(ack) > 1) multi_seen++;
      if (eng_start && n_seen < 4) begin
        check($sformatf("rr_grant%0d", n_seen), grant_id, order[n_seen]);
        check($sformatf("rr_rect%0d", n_seen), eng_rect(), exp_rect(order[n_seen]));
        n_seen++;
      end
    end
    req = '0;
    check("rr_jobs_seen", n_seen, 4);
    check("rr_no_err", err_seen, 0);
    check("rr_ack_onehot", multi_seen, 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      eng_busy = prev_start;
      prev_start = eng_start;
    end
    eng_busy = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
